// File: rtl/qbus_pkg.sv
// Shared definitions for the Q-bus initiator: FSM states, default timing and
// the vp_128 floppy controller register map.
package qbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SYNC,
        ST_DATA,
        ST_WAIT,
        ST_LATCH,
        ST_REL,
        ST_TAIL
    } qbus_state_t;

    localparam int QBUS_PHASE_DEF = 1;
    localparam int QBUS_TMO_DEF   = 64;
    localparam int QBUS_CNT_W     = 16;

    localparam logic [15:0] VP128_CSR    = 16'o177130;
    localparam logic [15:0] VP128_DATA   = 16'o177132;
    localparam int          VP128_CSR_TR = 7;

    // A state held for N cycles loads N-1 and leaves when the counter reads zero.
    function automatic logic [QBUS_CNT_W-1:0] cnt_load(input int cycles);
        return QBUS_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/qbus_sync.sv
// Two-flop synchronizer for an active-low asynchronous strobe; the output is
// active-high and reads deasserted out of reset.
module qbus_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_n_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_n_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = ~sync_q;

endmodule

// File: rtl/qbus_master.sv
// Q-bus initiator: runs one DATI or DATO cycle per accepted local request on the
// inverted multiplexed bus, with bounded waits on both edges of the slave's RPLY.
module qbus_master
    import qbus_pkg::*;
#(
    parameter int PHASE = QBUS_PHASE_DEF,
    parameter int TMO   = QBUS_TMO_DEF
) (
    input  logic        PIN_CLK,
    input  logic        PIN_INIT,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    input  logic [15:0] PIN_nAD_in,
    output logic [15:0] PIN_nAD_out,
    output logic        PIN_nAD_oe,
    output logic        PIN_nSYNC,
    output logic        PIN_nDIN,
    output logic        PIN_nDOUT,
    input  logic        PIN_nRPLY
);
    localparam logic [QBUS_CNT_W-1:0] PH_LOAD  = cnt_load(PHASE);
    localparam logic [QBUS_CNT_W-1:0] TMO_LOAD = cnt_load(TMO);

    qbus_state_t           state_q;
    logic [QBUS_CNT_W-1:0] cnt_q;
    logic                  we_q;
    logic [15:0]           wdata_q;
    logic                  err_r_q;
    logic                  ack_q;
    logic                  err_q;
    logic [15:0]           rdata_q;
    logic                  oe_q;
    logic [15:0]           nad_q;
    logic                  nsync_q;
    logic                  ndin_q;
    logic                  ndout_q;
    logic                  rply_s;
    logic                  cnt_zero;
    logic [QBUS_CNT_W-1:0] cnt_dec;

    qbus_sync u_rply_sync (
        .clk_i (PIN_CLK),
        .rst_i (PIN_INIT),
        .d_n_i (PIN_nRPLY),
        .q_o   (rply_s)
    );

    assign cnt_zero = (cnt_q == '0);
    assign cnt_dec  = cnt_q - QBUS_CNT_W'(1);

    always_ff @(posedge PIN_CLK) begin
        if (PIN_INIT) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            err_r_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            oe_q    <= 1'b0;
            nad_q   <= 16'hFFFF;
            nsync_q <= 1'b1;
            ndin_q  <= 1'b1;
            ndout_q <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        // The inverted address register doubles as the address latch.
                        we_q    <= we;
                        wdata_q <= wdata;
                        err_r_q <= 1'b0;
                        rdata_q <= '0;
                        oe_q    <= 1'b1;
                        nad_q   <= ~addr;
                        cnt_q   <= PH_LOAD;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (cnt_zero) begin
                        nsync_q <= 1'b0;
                        cnt_q   <= PH_LOAD;
                        state_q <= ST_SYNC;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                ST_SYNC: begin
                    if (cnt_zero) begin
                        if (we_q) begin
                            nad_q <= ~wdata_q;
                        end else begin
                            oe_q   <= 1'b0;
                            ndin_q <= 1'b0;
                        end
                        cnt_q   <= PH_LOAD;
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                ST_DATA: begin
                    if (cnt_zero) begin
                        if (we_q) begin
                            ndout_q <= 1'b0;
                        end
                        cnt_q   <= TMO_LOAD;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                ST_WAIT: begin
                    // A reply seen on the last allowed cycle still wins over the timeout.
                    if (rply_s) begin
                        cnt_q   <= PH_LOAD;
                        state_q <= ST_LATCH;
                    end else if (cnt_zero) begin
                        err_r_q <= 1'b1;
                        nsync_q <= 1'b1;
                        ndin_q  <= 1'b1;
                        ndout_q <= 1'b1;
                        cnt_q   <= TMO_LOAD;
                        state_q <= ST_REL;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                ST_LATCH: begin
                    if (cnt_zero) begin
                        if (!we_q) begin
                            rdata_q <= ~PIN_nAD_in;
                        end
                        nsync_q <= 1'b1;
                        ndin_q  <= 1'b1;
                        ndout_q <= 1'b1;
                        cnt_q   <= TMO_LOAD;
                        state_q <= ST_REL;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                ST_REL: begin
                    if (!rply_s) begin
                        cnt_q   <= PH_LOAD;
                        state_q <= ST_TAIL;
                    end else if (cnt_zero) begin
                        err_r_q <= 1'b1;
                        rdata_q <= '0;
                        cnt_q   <= PH_LOAD;
                        state_q <= ST_TAIL;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                ST_TAIL: begin
                    if (cnt_zero) begin
                        oe_q    <= 1'b0;
                        nad_q   <= 16'hFFFF;
                        ack_q   <= 1'b1;
                        err_q   <= err_r_q;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign ack         = ack_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign PIN_nAD_out = nad_q;
    assign PIN_nAD_oe  = oe_q;
    assign PIN_nSYNC   = nsync_q;
    assign PIN_nDIN    = ndin_q;
    assign PIN_nDOUT   = ndout_q;

endmodule

// File: tb/tb_qbus_master.sv
// Bench for qbus_master: a behavioural vp_128-style slave answers on the bus,
// and a scoreboard holds the rdata/err each accepted request must complete with.
module tb_qbus_master;
    import qbus_pkg::*;

    logic        clk = 1'b0;
    logic        init;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] nad_in;
    logic        nrply;
    logic        busy;
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] nad_out;
    logic        nad_oe;
    logic        nsync;
    logic        ndin;
    logic        ndout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // slave model controls and observations
    bit          resp_en    = 1'b1;
    int          resp_delay = 0;
    logic [15:0] data_reg   = 16'h0000;
    int          csr_reads  = 0;
    logic [15:0] wr_addr    = 16'h0000;
    logic [15:0] wr_data    = 16'h0000;
    logic [15:0] slv_addr   = 16'h0000;

    qbus_master #(.PHASE(1), .TMO(64)) dut (
        .PIN_CLK     (clk),
        .PIN_INIT    (init),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .ack         (ack),
        .err         (err),
        .rdata       (rdata),
        .PIN_nAD_in  (nad_in),
        .PIN_nAD_out (nad_out),
        .PIN_nAD_oe  (nad_oe),
        .PIN_nSYNC   (nsync),
        .PIN_nDIN    (ndin),
        .PIN_nDOUT   (ndout),
        .PIN_nRPLY   (nrply)
    );

    always #5 clk = ~clk;

    // Slave: latches the address on nSYNC falling, replies resp_delay cycles after
    // a strobe falls, releases RPLY once both strobes are high again.
    initial begin
        logic prev_nsync;
        logic [15:0] v;
        int dly;
        prev_nsync = 1'b1;
        dly = 0;
        nrply = 1'b1;
        nad_in = 16'hFFFF;
        forever begin
            @(posedge clk);
            #1;
            if (prev_nsync === 1'b1 && nsync === 1'b0) slv_addr = ~nad_out;
            prev_nsync = nsync;
            if (nrply === 1'b1) begin
                if (resp_en && (ndin === 1'b0 || ndout === 1'b0)) begin
                    if (dly >= resp_delay) begin
                        if (ndin === 1'b0) begin
                            if (slv_addr == VP128_CSR) begin
                                csr_reads++;
                                v = (csr_reads >= 4) ? 16'h0080 : 16'h0000;
                            end else begin
                                v = data_reg;
                            end
                            nad_in = ~v;
                        end else begin
                            wr_addr = slv_addr;
                            wr_data = ~nad_out;
                        end
                        nrply = 1'b0;
                        dly = 0;
                    end else begin
                        dly++;
                    end
                end else begin
                    dly = 0;
                end
            end else if (ndin === 1'b1 && ndout === 1'b1) begin
                nrply = 1'b1;
                nad_in = 16'hFFFF;
            end
        end
    end

    // Scoreboard and bus-rule monitor, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack rdata=%h err=%b required no ack", rdata, err);
                end else begin
                    e = sb.pop_front();
                    if (rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL sb_rdata got %h required %h", rdata, e.rdata);
                    end
                    checks++;
                    if (err !== e.err) begin
                        errors++;
                        $display("FAIL sb_err got %b required %b", err, e.err);
                    end
                end
            end
            checks++;
            if ((ndin === 1'b0 && ndout === 1'b0) || (ndin === 1'b0 && nad_oe === 1'b1)) begin
                errors++;
                $display("FAIL bus_rule ndin=%b ndout=%b oe=%b required no overlap", ndin, ndout, nad_oe);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd, input logic exp_er, input bit push);
        exp_t e;
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL issue_idle busy=%b required 0", busy);
        end
        req = 1'b1;
        we = w;
        addr = a;
        wdata = d;
        if (push) begin
            e.rdata = exp_rd;
            e.err = exp_er;
            sb.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output int lat, output bit ok);
        lat = 0;
        ok = 1'b0;
        while (lat < budget && !ok) begin
            @(negedge clk);
            lat++;
            if (ack === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        init = 1'b1;
        req = 1'b0;
        we = 1'b0;
        addr = 16'h0000;
        wdata = 16'h0000;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
        checks++; if (ack !== 1'b0)          begin errors++; $display("FAIL rst_ack got %b required 0", ack); end
        checks++; if (err !== 1'b0)          begin errors++; $display("FAIL rst_err got %b required 0", err); end
        checks++; if (rdata !== 16'h0000)    begin errors++; $display("FAIL rst_rdata got %h required 0000", rdata); end
        checks++; if (nad_oe !== 1'b0)       begin errors++; $display("FAIL rst_oe got %b required 0", nad_oe); end
        checks++; if (nad_out !== 16'hFFFF)  begin errors++; $display("FAIL rst_nad got %h required ffff", nad_out); end
        checks++; if (nsync !== 1'b1)        begin errors++; $display("FAIL rst_nsync got %b required 1", nsync); end
        checks++; if (ndin !== 1'b1)         begin errors++; $display("FAIL rst_ndin got %b required 1", ndin); end
        checks++; if (ndout !== 1'b1)        begin errors++; $display("FAIL rst_ndout got %b required 1", ndout); end
        init = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_csr();
        int n, rise_sync, rise_dout, fall_rply;
        bit seen_ack, dout_low;
        resp_en = 1'b1;
        resp_delay = 3;
        issue(1'b1, VP128_CSR, 16'o000001, 16'h0000, 1'b0, 1'b1);
        checks++;
        if (nad_out !== 16'o000647 || nad_oe !== 1'b1 || nsync !== 1'b1) begin
            errors++;
            $display("FAIL wr_addr_phase nad=%o oe=%b nsync=%b required 000647 1 1", nad_out, nad_oe, nsync);
        end
        @(negedge clk);
        checks++;
        if (nsync !== 1'b0) begin errors++; $display("FAIL wr_sync_phase nsync=%b required 0", nsync); end
        @(negedge clk);
        checks++;
        if (nad_out !== 16'o177776 || ndout !== 1'b1) begin
            errors++;
            $display("FAIL wr_data_phase nad=%o ndout=%b required 177776 1", nad_out, ndout);
        end
        n = 2; rise_sync = -1; rise_dout = -1; fall_rply = -1;
        seen_ack = 1'b0; dout_low = 1'b0;
        while (!seen_ack && n < 200) begin
            @(negedge clk);
            n++;
            if (fall_rply < 0 && nrply === 1'b0) fall_rply = n;
            if (ndout === 1'b0) dout_low = 1'b1;
            if (rise_dout < 0 && dout_low && ndout === 1'b1) rise_dout = n;
            if (rise_sync < 0 && nsync === 1'b1) rise_sync = n;
            if (ack === 1'b1) seen_ack = 1'b1;
        end
        checks++;
        if (n != 14) begin errors++; $display("FAIL wr_latency got %0d required 14", n); end
        checks++;
        if (rise_sync < 0 || rise_sync != rise_dout) begin
            errors++;
            $display("FAIL wr_release sync_rise=%0d dout_rise=%0d required equal", rise_sync, rise_dout);
        end
        checks++;
        if (fall_rply < 0 || fall_rply >= rise_sync) begin
            errors++;
            $display("FAIL wr_order rply_fall=%0d sync_rise=%0d required rply first", fall_rply, rise_sync);
        end
        checks++;
        if (wr_addr !== VP128_CSR || wr_data !== 16'o000001) begin
            errors++;
            $display("FAIL wr_slave got %o/%o required 177130/000001", wr_addr, wr_data);
        end
    endtask

    task automatic test_read_data();
        int n, din_low;
        bit seen_ack;
        resp_en = 1'b1;
        resp_delay = 0;
        data_reg = 16'h3130;
        issue(1'b0, VP128_DATA, 16'h0000, 16'h3130, 1'b0, 1'b1);
        n = 0; din_low = 0; seen_ack = 1'b0;
        while (!seen_ack && n < 200) begin
            @(negedge clk);
            n++;
            if (ndin === 1'b0) begin
                din_low++;
                checks++;
                if (nad_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_during_din got %b required 0", nad_oe); end
            end
            if (ack === 1'b1) seen_ack = 1'b1;
        end
        checks++;
        if (!seen_ack || din_low == 0) begin
            errors++;
            $display("FAIL rd_done ack=%b din_cycles=%0d required ack and din>0", seen_ack, din_low);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL rd_ack_width ack=%b required 0", ack); end
    endtask

    task automatic test_poll();
        int lat, polls;
        bit ok, done;
        resp_en = 1'b1;
        resp_delay = 1;
        polls = 0;
        done = 1'b0;
        while (!done && polls < 8) begin
            polls++;
            issue(1'b0, VP128_CSR, 16'h0000, (polls >= 4) ? 16'h0080 : 16'h0000, 1'b0, 1'b1);
            wait_ack(200, lat, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL poll_timeout poll=%0d lat=%0d required ack", polls, lat);
                done = 1'b1;
            end else if (rdata[VP128_CSR_TR] === 1'b1) begin
                done = 1'b1;
            end
        end
        checks++;
        if (polls != 4) begin errors++; $display("FAIL poll_count got %0d required 4", polls); end
    endtask

    task automatic test_timeout();
        int n, low;
        bit seen_ack;
        resp_en = 1'b0;
        issue(1'b1, VP128_CSR, 16'h1234, 16'h0000, 1'b1, 1'b1);
        n = 0; low = 0; seen_ack = 1'b0;
        while (!seen_ack && n < 300) begin
            @(negedge clk);
            n++;
            if (ndout === 1'b0) low++;
            if (ack === 1'b1) seen_ack = 1'b1;
        end
        checks++;
        if (low != 64) begin errors++; $display("FAIL tmo_wait_len got %0d required 64", low); end
        issue(1'b0, VP128_DATA, 16'h0000, 16'h0000, 1'b1, 1'b1);
        n = 0; low = 0; seen_ack = 1'b0;
        while (!seen_ack && n < 300) begin
            @(negedge clk);
            n++;
            if (ndin === 1'b0) low++;
            if (ack === 1'b1) seen_ack = 1'b1;
        end
        checks++;
        if (low != 65) begin errors++; $display("FAIL tmo_din_len got %0d required 65", low); end
        @(negedge clk);
        checks++;
        if (nad_oe !== 1'b0 || nad_out !== 16'hFFFF || nsync !== 1'b1 || ndin !== 1'b1 || ndout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_release oe=%b nad=%h sync=%b din=%b dout=%b required 0 ffff 1 1 1",
                     nad_oe, nad_out, nsync, ndin, ndout);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int guard, lat;
        bit ok;
        resp_en = 1'b0;
        issue(1'b1, VP128_DATA, 16'h5555, 16'h0000, 1'b0, 1'b0);
        guard = 0;
        while (ndout !== 1'b0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        checks++;
        if (nsync !== 1'b1 || ndout !== 1'b1 || nad_oe !== 1'b0 || busy !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset sync=%b dout=%b oe=%b busy=%b ack=%b required 1 1 0 0 0",
                     nsync, ndout, nad_oe, busy, ack);
        end
        checks++;
        if (nad_out !== 16'hFFFF) begin errors++; $display("FAIL mid_reset_nad got %h required ffff", nad_out); end
        repeat (6) @(negedge clk);
        resp_en = 1'b1;
        resp_delay = 0;
        data_reg = 16'hA5C3;
        issue(1'b0, VP128_DATA, 16'h0000, 16'hA5C3, 1'b0, 1'b1);
        wait_ack(200, lat, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_after_read ack=%b required 1", ok); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n, n_ack1, rise1, fall2;
        bit seen1, seen2, low1;
        resp_en = 1'b1;
        resp_delay = 0;
        data_reg = 16'h0F0F;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        req = 1'b1; we = 1'b1; addr = VP128_CSR; wdata = 16'h0002;
        e.rdata = 16'h0000; e.err = 1'b0; sb.push_back(e);
        @(negedge clk);
        we = 1'b0; addr = VP128_DATA; wdata = 16'h0000;
        e.rdata = 16'h0F0F; e.err = 1'b0; sb.push_back(e);
        n = 0; n_ack1 = -1; rise1 = -1; fall2 = -1;
        seen1 = 1'b0; seen2 = 1'b0; low1 = 1'b0;
        while (!seen2 && n < 300) begin
            @(negedge clk);
            n++;
            if (nsync === 1'b0 && rise1 < 0) low1 = 1'b1;
            if (low1 && rise1 < 0 && nsync === 1'b1) rise1 = n;
            if (rise1 >= 0 && fall2 < 0 && nsync === 1'b0) fall2 = n;
            if (ack === 1'b1) begin
                if (seen1) seen2 = 1'b1;
                else begin seen1 = 1'b1; n_ack1 = n; end
            end
            if (n == n_ack1 + 1 && seen1) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart busy=%b required 1", busy); end
                req = 1'b0;
            end
        end
        req = 1'b0;
        checks++;
        if (n_ack1 != 11) begin errors++; $display("FAIL b2b_wr_latency got %0d required 11", n_ack1); end
        checks++;
        if (!seen2) begin errors++; $display("FAIL b2b_second_ack seen=%b required 1", seen2); end
        checks++;
        if (rise1 < 0 || fall2 < 0 || (fall2 - rise1) < 2) begin
            errors++;
            $display("FAIL b2b_sync_gap rise=%0d fall=%0d required gap>=2", rise1, fall2);
        end
        checks++;
        if (wr_data !== 16'h0002) begin errors++; $display("FAIL b2b_wdata got %h required 0002", wr_data); end
    endtask

    initial begin
        test_reset();
        test_write_csr();
        test_read_data();
        test_poll();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d required 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
